// File: rtl/toggle_led_sequencer.sv
// toggle_led_sequencer: turns upstream toggle edges into ticks and steps a PWM-dimmed one-hot LED.
// Optional macro SEQ_BOUNCE_EN: reflect at the ends instead of wrapping.
module toggle_led_sequencer #(
  parameter int LED_W = 8,
  parameter int DIV   = 4,
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             toggle_in,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [PWM_W-1:0] duty,
  output logic [LED_W-1:0] led,
  output logic [7:0]       step_count,
  output logic             busy,
  output logic             wrap_pulse
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [LED_W-1:0] r_pos;
  logic [LED_W-1:0] w_pos_nxt;
  logic [DW-1:0]    r_div;
  logic [PWM_W-1:0] r_pwm;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_wrap;
  logic [LED_W-1:0] r_led;
  logic             w_tick;
  logic             w_step;
  logic             w_dn;
  logic             w_end;
  logic             w_mv_dn;
  logic             w_gate;

  assign w_tick = r_s2 ^ r_s3;
  assign w_gate = (&duty) | (r_pwm < duty);
  assign w_step = (r_state == ST_RUN) & w_tick
                & (r_div == DW'(DIV - 1)) & ~stop;

`ifdef SEQ_BOUNCE_EN
  logic r_dir;

  // At an end the move is mirrored and the held direction flips
  assign w_dn    = r_dir;
  assign w_end   = w_dn ? r_pos[0] : r_pos[LED_W-1];
  assign w_mv_dn = w_dn ^ w_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 1'b0;
    end else if (r_state == ST_IDLE && start && !stop) begin
      r_dir <= dir;
    end else if (w_step && w_end) begin
      r_dir <= ~r_dir;
    end
  end
`else
  assign w_dn    = dir;
  assign w_end   = w_dn ? r_pos[0] : r_pos[LED_W-1];
  assign w_mv_dn = w_dn;
`endif

  assign w_pos_nxt = w_mv_dn ? {r_pos[0], r_pos[LED_W-1:1]}
                             : {r_pos[LED_W-2:0], r_pos[LED_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    if (stop) begin
      w_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (start) w_nxt = ST_RUN;
        ST_RUN:   if (!en)   w_nxt = ST_PAUSE;
        ST_PAUSE: if (en)    w_nxt = ST_RUN;
        default:             w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_pwm  <= '0;
      r_busy <= 1'b0;
      r_led  <= '0;
      r_wrap <= 1'b0;
      r_pos  <= LED_W'(1);
      r_div  <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= toggle_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pwm  <= r_pwm + 1'b1;
      r_busy <= (w_nxt != ST_IDLE);
      r_led  <= r_busy ? (r_pos & {LED_W{w_gate}}) : '0;
      r_wrap <= 1'b0;
      if (stop || r_state == ST_IDLE) begin
        r_pos <= LED_W'(1);
        r_div <= '0;
      end else if (w_step) begin
        r_div  <= '0;
        r_pos  <= w_pos_nxt;
        r_cnt  <= r_cnt + 8'd1;
        r_wrap <= w_end;
      end else if (r_state == ST_RUN && w_tick) begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign led        = r_led;
  assign step_count = r_cnt;
  assign busy       = r_busy;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_toggle_led_sequencer.sv
// tb_toggle_led_sequencer: scoreboarded bench for toggle_led_sequencer.
// Expected steps are queued as toggles are driven and popped when step_count moves.
module tb_toggle_led_sequencer;

  localparam int LW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          toggle_in = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [PW-1:0] duty = '1;
  logic [LW-1:0] led;
  logic [7:0]    step_count;
  logic          busy;
  logic          wrap_pulse;

  typedef struct {
    logic [7:0] pos;
    logic [7:0] cnt;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drive_cyc = 0;
  int step_cyc = 0;
  int step_gap = 0;

  logic [7:0] m_pos = 8'h01;
  logic [7:0] m_cnt = 8'h00;
  int         m_div = 0;
  bit         m_run = 1'b0;

  logic [7:0] prev_cnt = 8'h00;
  bit         led_chk = 1'b0;
  logic [7:0] led_exp = 8'h00;

  toggle_led_sequencer #(
    .LED_W(LW),
    .DIV  (4),
    .PWM_W(PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toggle_in (toggle_in),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .duty      (duty),
    .led       (led),
    .step_count(step_count),
    .busy      (busy),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_cnt = step_count;
      led_chk  = 1'b0;
    end else begin
      if (led_chk) begin
        led_chk = 1'b0;
        checks++;
        if (led !== led_exp || wrap_pulse !== 1'b0) begin
          failures++;
          $display("FAIL step_led: led=%h wrap=%b required led=%h wrap=0",
                   led, wrap_pulse, led_exp);
        end
      end
      if (step_count !== prev_cnt) begin
        step_gap = cyc - step_cyc;
        step_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL step_unexpected: step_count=%0d required no step",
                   step_count);
        end else begin
          e = sb.pop_front();
          if (step_count !== e.cnt || wrap_pulse !== e.wrap) begin
            failures++;
            $display("FAIL step_cnt: cnt=%0d wrap=%b required cnt=%0d wrap=%b",
                     step_count, wrap_pulse, e.cnt, e.wrap);
          end
          led_exp = e.pos;
          led_chk = 1'b1;
        end
      end
      prev_cnt = step_count;
    end
  end

  task automatic tog();
    logic w;
    @(posedge clk);
    #1;
    toggle_in = ~toggle_in;
    drive_cyc = cyc;
    if (m_run) begin
      m_div++;
      if (m_div == 4) begin
        m_div = 0;
        m_cnt = m_cnt + 8'd1;
        if (!dir) begin
          w = m_pos[7];
          m_pos = w ? 8'h01 : (m_pos << 1);
        end else begin
          w = m_pos[0];
          m_pos = w ? 8'h80 : (m_pos >> 1);
        end
        sb.push_back('{pos: m_pos, cnt: m_cnt, wrap: w});
      end
    end
    repeat (9) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_run = 1'b1;
    m_pos = 8'h01;
    m_div = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL reset_led: got %h required 00", led);
    end
    checks++;
    if (step_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_cnt: got %0d required 0", step_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap: got %b required 0", wrap_pulse);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_step_up();
    en = 1'b1;
    dir = 1'b0;
    duty = '1;
    pulse_start();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy: got %b required 1", busy);
    end
    repeat (4) tog();
    checks++;
    if (step_cyc - drive_cyc != 3) begin
      failures++;
      $display("FAIL step_latency: got %0d required 3", step_cyc - drive_cyc);
    end
    repeat (28) tog();
    checks++;
    if (step_gap != 40) begin
      failures++;
      $display("FAIL step_gap: got %0d required 40", step_gap);
    end
    checks++;
    if (step_count !== 8'd8 || led !== 8'h01) begin
      failures++;
      $display("FAIL wrap_up: cnt=%0d led=%h required cnt=8 led=01",
               step_count, led);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL step_up_drain: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_dir_down();
    dir = 1'b1;
    repeat (8) tog();
    checks++;
    if (led !== 8'h40 || step_count !== 8'd10) begin
      failures++;
      $display("FAIL dir_down: led=%h cnt=%0d required led=40 cnt=10",
               led, step_count);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL dir_drain: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_pause();
    repeat (2) tog();
    @(posedge clk);
    #1 en = 1'b0;
    m_run = 1'b0;
    repeat (10) tog();
    checks++;
    if (busy !== 1'b1 || led !== 8'h40 || step_count !== 8'd10) begin
      failures++;
      $display("FAIL pause_hold: busy=%b led=%h cnt=%0d required 1 40 10",
               busy, led, step_count);
    end
    @(posedge clk);
    #1 en = 1'b1;
    m_run = 1'b1;
    repeat (2) tog();
    checks++;
    if (led !== 8'h20 || step_count !== 8'd11) begin
      failures++;
      $display("FAIL pause_resume: led=%h cnt=%0d required led=20 cnt=11",
               led, step_count);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pause_drain: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_pwm();
    int on_cnt;
    int stray;
    repeat (8) tog();
    checks++;
    if (led !== 8'h08) begin
      failures++;
      $display("FAIL pwm_pos: got %h required 08", led);
    end
    duty = 4'd4;
    on_cnt = 0;
    stray = 0;
    repeat (2) @(posedge clk);
    repeat (32) begin
      @(negedge clk);
      if (led[3] === 1'b1) on_cnt++;
      if ((led & 8'hF7) !== 8'h00) stray++;
    end
    checks++;
    if (on_cnt != 8 || stray != 0) begin
      failures++;
      $display("FAIL pwm_duty4: on=%0d stray=%0d required on=8 stray=0",
               on_cnt, stray);
    end
    duty = 4'd0;
    on_cnt = 0;
    repeat (2) @(posedge clk);
    repeat (32) begin
      @(negedge clk);
      if (led !== 8'h00) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin
      failures++;
      $display("FAIL pwm_duty0: lit=%0d required 0", on_cnt);
    end
    duty = '1;
  endtask

  task automatic test_stop();
    @(posedge clk);
    #1;
    start = 1'b1;
    stop = 1'b1;
    m_run = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_busy: got %b required 0", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (led !== 8'h00 || step_count !== 8'd13) begin
      failures++;
      $display("FAIL stop_out: led=%h cnt=%0d required led=00 cnt=13",
               led, step_count);
    end
    repeat (4) tog();
    dir = 1'b0;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (led !== 8'h01) begin
      failures++;
      $display("FAIL restart_pos: got %h required 01", led);
    end
    repeat (4) tog();
    checks++;
    if (led !== 8'h02 || step_count !== 8'd14) begin
      failures++;
      $display("FAIL restart_step: led=%h cnt=%0d required led=02 cnt=14",
               led, step_count);
    end
    repeat (2) tog();
    @(posedge clk);
    #3 rst_n = 1'b0;
    m_run = 1'b0;
    m_cnt = 8'h00;
    #1;
    checks++;
    if (led !== 8'h00 || busy !== 1'b0 || step_count !== 8'h00
        || wrap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: led=%h busy=%b cnt=%0d wrap=%b required 00 0 0 0",
               led, busy, step_count, wrap_pulse);
    end
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
    pulse_start();
    repeat (4) tog();
    checks++;
    if (led !== 8'h02 || step_count !== 8'd1) begin
      failures++;
      $display("FAIL post_reset_step: led=%h cnt=%0d required led=02 cnt=1",
               led, step_count);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL stop_drain: got %0d pending required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_dir_down();
    test_pause();
    test_pwm();
    test_stop();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
